esaxi_tx_arbiter: RTL
=====================

// Module: esaxi_tx_arbiter
// PURPOSE
//  Shares the single eMesh transmit packet port between the AXI-slave write path and read-request path.
//  Round-robin between the two; a multi-beat burst keeps its grant until its last beat is accepted.
//  Drives the per-path ready (write_ready / read_ready) that backpressures each bridge.
//  One registered output stage faces the eMesh TX port; 16-bit saturating beat counters are kept for debug.
// PARAMETERS
//  AW      32   address width (fixed; packet layout depends on it)
//  DW      32   data width (fixed)
//  PW      104  eMesh packet width = 32+32+32+4+2+1+1
//  CNTW    16   width of beat statistic counters
// PORTS
//  clk          in   1    clock
//  rst          in   1    reset, synchronous, active-high
//  wr_valid     in   1    write beat available from write bridge
//  wr_last      in   1    beat is last of write burst
//  wr_addr      in   32   write destination address
//  wr_data      in   32   write data
//  wr_size      in   3    AXI size (bits [1:0] -> datamode)
//  write_ready  out  1    write beat accepted this cycle when wr_valid=1
//  rd_valid     in   1    read-request beat available from read bridge
//  rd_last      in   1    beat is last of read burst
//  rd_addr      in   32   read source address
//  rd_retaddr   in   32   return address for read data
//  rd_size      in   3    AXI size
//  read_ready   out  1    read beat accepted this cycle when rd_valid=1
//  ctrlmode     in   4    ctrlmode field copied into every packet
//  tx_access    out  1    packet valid toward eMesh
//  tx_packet    out  104  packet
//  tx_wait      in   1    eMesh stall; packet must hold while tx_access & tx_wait
//  stat_clr     in   1    synchronous clear of beat counters
//  wr_beats     out  16   accepted write beats, saturating
//  rd_beats     out  16   accepted read beats, saturating
// BEHAVIOUR
//  Reset: tx_access=0, tx_packet=0, wr_beats=rd_beats=0, state=IDLE, rr_last=READ (write wins first tie).
//  stage_free = !tx_access | !tx_wait. No beat is accepted when stage_free=0.
//  Ready outputs are combinational:
//   write_ready = stage_free & grant_wr; read_ready = stage_free & grant_rd.
//  FSM states: IDLE, WR_BURST, RD_BURST.
//   IDLE: grant_wr = wr_valid & (!rd_valid | rr_last==READ); grant_rd = rd_valid & !grant_wr.
//     Accepted beat with last=0 -> WR_BURST/RD_BURST.
//     Accepted beat with last=1 -> stay IDLE, rr_last=that path.
//   WR_BURST: grant_wr=1, grant_rd=0.
//     Accepted wr beat with wr_last=1 -> IDLE, rr_last=WRITE.
//   RD_BURST: mirror of WR_BURST.
//   In a burst state, an idle requester (valid=0) holds the state; no timeout.
//  Load: accepted beat sets tx_access=1 and tx_packet next cycle (latency 1).
//   If stage_free and nothing accepted, tx_access->0.
//  Packet {[103:72] srcaddr, [71:40] data, [39:8] dstaddr, [7:4] ctrlmode, [3:2] datamode, [1] write, [0] 1}
//   write: srcaddr=0, data=wr_data, dstaddr=wr_addr, datamode=wr_size[1:0], write=1.
//   read:  srcaddr=rd_retaddr, data=0, dstaddr=rd_addr, datamode=rd_size[1:0], write=0.
//  tx_wait=1 with tx_access=1: tx_packet and tx_access hold exactly; both readies are 0.
//  Counters: +1 per accepted beat; hold at 16'hFFFF.
//   stat_clr has priority over the increment in the same cycle (result 0).
//  Reset mid-burst: FSM->IDLE, output stage dropped; partial burst is not resumed.
// TESTING
//  Reset: rst 2 cycles -> tx_access=0, tx_packet=0, ready outputs 0 with no valid, counters 0.
//  Single write: wr_valid=1, wr_last=1, addr=0x8000_0010, data=0xDEADBEEF, size=2
//   -> write_ready same cycle; next cycle tx_access=1,
//   tx_packet={32'h0,32'hDEADBEEF,32'h80000010,ctrlmode,2'b10,1'b1,1'b1}.
//  Tie after reset: wr and rd single beats both valid -> write first, read next cycle; repeat tie -> write again (rr alternates).
//  Burst lock: 4-beat write (last on beat 4) with rd_valid=1 throughout
//   -> read_ready=0 for the 4 beats; read granted in the cycle after beat 4 is accepted.
//  Backpressure: tx_wait=1 for 3 cycles on a loaded packet -> tx_packet stable, write_ready=0;
//   tx_wait drops -> next beat accepted.
//  Saturation/clear: force 65537 write beats -> wr_beats=16'hFFFF;
//   stat_clr with a simultaneous beat -> 0; reset mid-burst -> state IDLE, tx_access=0.

Source files
------------

// File: rtl/esaxi_tx_arbiter.sv
// -----------------------------------------------------------------------------
// esaxi_tx_arbiter
//
// Purpose:
//   Shares the single eMesh transmit packet port between the AXI-slave write
//   path and the read-request path. The two paths are served round-robin.
//   A multi-beat burst keeps its grant until its last beat is accepted.
//   A single registered output stage faces the eMesh TX port. Two 16-bit
//   saturating beat counters are kept for debug.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   wr_*           write beat from the write bridge (valid/last/addr/data/size)
//   write_ready    write beat accepted this cycle when wr_valid=1
//   rd_*           read-request beat from the read bridge
//                  (valid/last/addr/retaddr/size)
//   read_ready     read beat accepted this cycle when rd_valid=1
//   ctrlmode       ctrlmode field copied into every packet
//   tx_access      packet valid toward eMesh
//   tx_packet      packet toward eMesh
//   tx_wait        eMesh stall; the packet holds while tx_access & tx_wait
//   stat_clr       synchronous clear of the beat counters
//   wr_beats       accepted write beats, saturating
//   rd_beats       accepted read beats, saturating
// -----------------------------------------------------------------------------
module esaxi_tx_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int PW   = 104,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    input  logic            wr_last,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [2:0]      wr_size,
    output logic            write_ready,
    input  logic            rd_valid,
    input  logic            rd_last,
    input  logic [AW-1:0]   rd_addr,
    input  logic [AW-1:0]   rd_retaddr,
    input  logic [2:0]      rd_size,
    output logic            read_ready,
    input  logic [3:0]      ctrlmode,
    output logic            tx_access,
    output logic [PW-1:0]   tx_packet,
    input  logic            tx_wait,
    input  logic            stat_clr,
    output logic [CNTW-1:0] wr_beats,
    output logic [CNTW-1:0] rd_beats
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2
    } state_t;

    state_t          state_q, state_d;
    // 1 when the write path was the last one to finish a transfer; the other
    // path then wins the next tie. Reset to 0 so the write path wins first.
    logic            rr_last_wr_q, rr_last_wr_d;
    logic            tx_access_q;
    logic [PW-1:0]   tx_packet_q;

    logic            stage_free;
    logic            grant_wr, grant_rd;
    logic            wr_acc, rd_acc;
    logic [PW-1:0]   pkt_wr, pkt_rd;

    // Only size bits [1:0] encode datamode; bit 2 is intentionally dropped.
    logic            unused_size_bits;
    assign unused_size_bits = &{1'b0, wr_size[2], rd_size[2]};

    // The output stage can take a new beat when it is empty or draining.
    assign stage_free = !tx_access_q || !tx_wait;

    // -------------------------------------------------------------------------
    // Grant / FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        state_d      = state_q;
        rr_last_wr_d = rr_last_wr_q;

        case (state_q)
            ST_WR_BURST: grant_wr = 1'b1;
            ST_RD_BURST: grant_rd = 1'b1;
            default: begin
                grant_wr = wr_valid && (!rd_valid || !rr_last_wr_q);
                grant_rd = rd_valid && !grant_wr;
            end
        endcase

        write_ready = stage_free && grant_wr;
        read_ready  = stage_free && grant_rd;
        wr_acc      = write_ready && wr_valid;
        rd_acc      = read_ready && rd_valid;

        // A burst state is left only when its own last beat is accepted; an
        // idle requester inside a burst simply holds the state.
        if (wr_acc) begin
            if (wr_last) begin
                state_d      = ST_IDLE;
                rr_last_wr_d = 1'b1;
            end else begin
                state_d      = ST_WR_BURST;
            end
        end else if (rd_acc) begin
            if (rd_last) begin
                state_d      = ST_IDLE;
                rr_last_wr_d = 1'b0;
            end else begin
                state_d      = ST_RD_BURST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_last_wr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_wr_q <= rr_last_wr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Packet formation and output stage
    // -------------------------------------------------------------------------
    assign pkt_wr = {{AW{1'b0}}, wr_data, wr_addr, ctrlmode, wr_size[1:0], 1'b1, 1'b1};
    assign pkt_rd = {rd_retaddr, {DW{1'b0}}, rd_addr, ctrlmode, rd_size[1:0], 1'b0, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_access_q <= 1'b0;
            tx_packet_q <= '0;
        end else if (stage_free) begin
            tx_access_q <= wr_acc || rd_acc;
            if (wr_acc) begin
                tx_packet_q <= pkt_wr;
            end else if (rd_acc) begin
                tx_packet_q <= pkt_rd;
            end
        end
    end

    assign tx_access = tx_access_q;
    assign tx_packet = tx_packet_q;

    // -------------------------------------------------------------------------
    // Saturating beat counters: index 0 = write, 1 = read
    // -------------------------------------------------------------------------
    logic [CNTW-1:0] beat_cnt_q [2];
    logic [1:0]      beat_acc;

    assign beat_acc = {rd_acc, wr_acc};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                // Clear wins over a simultaneous increment.
                if (rst || stat_clr) begin
                    beat_cnt_q[gi] <= '0;
                end else if (beat_acc[gi] && (beat_cnt_q[gi] != {CNTW{1'b1}})) begin
                    beat_cnt_q[gi] <= beat_cnt_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign wr_beats = beat_cnt_q[0];
    assign rd_beats = beat_cnt_q[1];

endmodule
